// File: rtl/time_set_counter.sv
// Editable hours/minutes register with binary and BCD outputs; one rising edge of step = one step.
// Inputs are registered once, so a step or load seen at edge N lands at edge N+1; no backpressure.
module time_set_counter #(
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned MIN_MAX  = 59
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic       step,
  input  logic       dir,
  input  logic       field,
  input  logic       edit_en,
  input  logic       load,
  input  logic [4:0] load_hours,
  input  logic [5:0] load_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [1:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [2:0] min_tens,
  output logic [3:0] min_ones,
  output logic       changed,
  output logic       wrapped
);

  localparam logic [4:0] H_MAX = HOUR_MAX[4:0];
  localparam logic [5:0] M_MAX = MIN_MAX[5:0];

  logic       step_q, step_d, dir_q, field_q, edit_en_q, load_q;
  logic [4:0] load_hours_q;
  logic [5:0] load_minutes_q;
  logic [4:0] hours_nx;
  logic [5:0] minutes_nx;
  logic       wrap_nx;
  logic       step_edge;

  // Ones digit is v - 10*tens; only the low nibble matters since the result is < 10.
  function automatic logic [5:0] hr_bcd(input logic [4:0] v);
    logic [1:0] t;
    logic [3:0] o;
    t = (v >= 5'd20) ? 2'd2 : (v >= 5'd10) ? 2'd1 : 2'd0;
    o = v[3:0] - ({t[0], 3'b000} + {1'b0, t, 1'b0});
    return {t, o};
  endfunction

  function automatic logic [6:0] min_bcd(input logic [5:0] v);
    logic [2:0] t;
    logic [3:0] o;
    t = (v >= 6'd50) ? 3'd5 : (v >= 6'd40) ? 3'd4 : (v >= 6'd30) ? 3'd3 :
        (v >= 6'd20) ? 3'd2 : (v >= 6'd10) ? 3'd1 : 3'd0;
    o = v[3:0] - ({t[0], 3'b000} + {t, 1'b0});
    return {t, o};
  endfunction

  assign step_edge = step_q & ~step_d;

  always_comb begin
    hours_nx   = hours;
    minutes_nx = minutes;
    wrap_nx    = 1'b0;
    if (load_q) begin
      hours_nx   = (load_hours_q > H_MAX) ? H_MAX : load_hours_q;
      minutes_nx = (load_minutes_q > M_MAX) ? M_MAX : load_minutes_q;
    end else if (step_edge && edit_en_q) begin
      if (field_q) begin
        if (!dir_q) begin
          if (hours == H_MAX) begin
            hours_nx = '0;
            wrap_nx  = 1'b1;
          end else begin
            hours_nx = hours + 5'd1;
          end
        end else begin
          if (hours == '0) begin
            hours_nx = H_MAX;
            wrap_nx  = 1'b1;
          end else begin
            hours_nx = hours - 5'd1;
          end
        end
      end else begin
        if (!dir_q) begin
          if (minutes == M_MAX) begin
            minutes_nx = '0;
            wrap_nx    = 1'b1;
          end else begin
            minutes_nx = minutes + 6'd1;
          end
        end else begin
          if (minutes == '0) begin
            minutes_nx = M_MAX;
            wrap_nx    = 1'b1;
          end else begin
            minutes_nx = minutes - 6'd1;
          end
        end
      end
    end
  end

  // step_q/step_d reset high so a press already held through reset is not counted.
  always_ff @(posedge clk_100Hz) begin
    if (rst) begin
      step_q         <= 1'b1;
      step_d         <= 1'b1;
      dir_q          <= 1'b0;
      field_q        <= 1'b0;
      edit_en_q      <= 1'b0;
      load_q         <= 1'b0;
      load_hours_q   <= '0;
      load_minutes_q <= '0;
      hours          <= '0;
      minutes        <= '0;
      hr_tens        <= '0;
      hr_ones        <= '0;
      min_tens       <= '0;
      min_ones       <= '0;
      changed        <= 1'b0;
      wrapped        <= 1'b0;
    end else begin
      step_q         <= step;
      step_d         <= step_q;
      dir_q          <= dir;
      field_q        <= field;
      edit_en_q      <= edit_en;
      load_q         <= load;
      load_hours_q   <= load_hours;
      load_minutes_q <= load_minutes;
      hours          <= hours_nx;
      minutes        <= minutes_nx;
      {hr_tens, hr_ones}   <= hr_bcd(hours_nx);
      {min_tens, min_ones} <= min_bcd(minutes_nx);
      changed        <= (hours_nx != hours) || (minutes_nx != minutes);
      wrapped        <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_time_set_counter.sv
// Directed bench for time_set_counter: table of single steps plus multi-cycle sequences.
module tb_time_set_counter;

  logic       clk_100Hz = 1'b0;
  logic       rst, step, dir, field, edit_en, load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [1:0] hr_tens;
  logic [3:0] hr_ones;
  logic [2:0] min_tens;
  logic [3:0] min_ones;
  logic       changed, wrapped;

  int n_pass = 0;
  int n_total = 0;

  time_set_counter dut (
    .clk_100Hz(clk_100Hz), .rst(rst), .step(step), .dir(dir), .field(field),
    .edit_en(edit_en), .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
    .hours(hours), .minutes(minutes), .hr_tens(hr_tens), .hr_ones(hr_ones),
    .min_tens(min_tens), .min_ones(min_ones), .changed(changed), .wrapped(wrapped)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  typedef struct {
    int lh; int lm; logic fld; logic dr;
    int eh; int em; int ew;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk_100Hz);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(input string tag, input int eh, input int em);
    chk({tag, " hours"}, int'(hours), eh);
    chk({tag, " minutes"}, int'(minutes), em);
    chk({tag, " hr_tens"}, int'(hr_tens), eh / 10);
    chk({tag, " hr_ones"}, int'(hr_ones), eh % 10);
    chk({tag, " min_tens"}, int'(min_tens), em / 10);
    chk({tag, " min_ones"}, int'(min_ones), em % 10);
  endtask

  // Values become visible after the second tick; a third tick lets any changed pulse clear.
  task automatic do_load(input int lh, input int lm);
    load = 1'b1;
    load_hours = 5'(lh);
    load_minutes = 6'(lm);
    tick();
    load = 1'b0;
    tick();
    tick();
  endtask

  int cc, wc, idx;
  int exp_seq[10] = '{56, 57, 58, 59, 0, 1, 2, 3, 4, 5};

  initial begin
    vecs[0] = '{0, 59, 1'b0, 1'b0, 0, 0, 1};
    vecs[1] = '{0, 10, 1'b1, 1'b1, 23, 10, 1};
    vecs[2] = '{12, 34, 1'b0, 1'b0, 12, 35, 0};
    vecs[3] = '{12, 34, 1'b1, 1'b0, 13, 34, 0};
    vecs[4] = '{23, 0, 1'b1, 1'b0, 0, 0, 1};
    vecs[5] = '{5, 0, 1'b0, 1'b1, 5, 59, 1};
    vecs[6] = '{9, 9, 1'b1, 1'b0, 10, 9, 0};
    vecs[7] = '{19, 49, 1'b0, 1'b0, 19, 50, 0};
    vecs[8] = '{30, 63, 1'b0, 1'b1, 23, 58, 0};

    rst = 1'b1; step = 1'b1; dir = 1'b0; field = 1'b0; edit_en = 1'b1;
    load = 1'b0; load_hours = '0; load_minutes = '0;

    // Reset release with step held high
    tick(); tick();
    rst = 1'b0;
    chk_all("reset", 0, 0);
    chk("reset changed", int'(changed), 0);
    chk("reset wrapped", int'(wrapped), 0);
    cc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cc += int'(changed);
    end
    chk("held step no change minutes", int'(minutes), 0);
    chk("held step changed count", cc, 0);
    step = 1'b0; tick();
    step = 1'b1; tick();
    tick();
    chk_all("first step", 0, 1);
    chk("first step changed", int'(changed), 1);
    tick();
    chk("first step changed clears", int'(changed), 0);
    step = 1'b0; tick(); tick();

    // Table of single steps after a load
    foreach (vecs[i]) begin
      do_load(vecs[i].lh, vecs[i].lm);
      field = vecs[i].fld;
      dir = vecs[i].dr;
      step = 1'b1; tick();
      step = 1'b0; tick();
      chk_all($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em);
      chk($sformatf("vec%0d changed", i), int'(changed), 1);
      chk($sformatf("vec%0d wrapped", i), int'(wrapped), vecs[i].ew);
      tick();
      chk($sformatf("vec%0d wrapped clears", i), int'(wrapped), 0);
      chk($sformatf("vec%0d changed clears", i), int'(changed), 0);
    end

    // Auto-repeat: 25-cycle square wave for 10 periods from 0:55
    field = 1'b0; dir = 1'b0;
    do_load(0, 55);
    cc = 0; wc = 0; idx = 0;
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 25; c++) begin
        step = (c < 12);
        tick();
        if (changed) begin
          if (idx < 10) chk($sformatf("repeat minutes[%0d]", idx), int'(minutes), exp_seq[idx]);
          idx++;
          cc++;
        end
        wc += int'(wrapped);
        chk("repeat hours held", int'(hours), 0);
      end
    end
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cc += int'(changed);
      wc += int'(wrapped);
    end
    chk("repeat changed count", cc, 10);
    chk("repeat wrapped count", wc, 1);
    chk_all("repeat end", 0, 5);

    // Load coinciding with a step edge: clamped, step discarded not deferred
    do_load(1, 1);
    field = 1'b0; dir = 1'b0;
    load = 1'b1; load_hours = 5'd30; load_minutes = 6'd63; step = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk_all("clamp", 23, 59);
    chk("clamp wrapped", int'(wrapped), 0);
    wc = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      wc += int'(wrapped);
    end
    chk("clamp no deferred step", int'(minutes), 59);
    chk("clamp wrapped count", wc, 0);
    step = 1'b0; tick(); tick();

    // Gating: edges with edit_en low are dropped
    edit_en = 1'b0; field = 1'b1; dir = 1'b1;
    cc = 0;
    for (int e = 0; e < 3; e++) begin
      step = 1'b1; tick(); cc += int'(changed); tick(); cc += int'(changed);
      step = 1'b0; tick(); cc += int'(changed); tick(); cc += int'(changed);
    end
    chk("gated changed count", cc, 0);
    chk_all("gated", 23, 59);
    edit_en = 1'b1; tick();
    step = 1'b1;
    cc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cc += int'(changed);
    end
    step = 1'b0;
    chk("ungated changed count", cc, 1);
    chk_all("ungated", 22, 59);
    tick(); tick();

    // Reset during a long press: no step until step falls and rises again
    step = 1'b1; tick(); tick(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    cc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cc += int'(changed);
    end
    chk_all("reset mid press", 0, 0);
    chk("reset mid press changed", cc, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
